// File: rtl/led_pattern_gen.sv
// Run-time LED pattern engine: static, blink, rotate and bounce animations
// stepped by an internal tick prescaler, with a global PWM brightness stage.
//
// mode_r       | meaning
// -------------+---------------------------------------------------------
// MODE_STATIC  | pat_r held, no animation
// MODE_BLINK   | pat_r shown while phase_r=1, blanked while phase_r=0
// MODE_ROTATE  | pat_r rotates left one position per tick
// MODE_BOUNCE  | pat_r shifts in dir_r, reversing when the block hits an edge
//
// dir_r        | meaning
// -------------+---------------------------------------------------------
// DIR_LEFT     | bounce moves towards the MSB
// DIR_RIGHT    | bounce moves towards the LSB
module led_pattern_gen #(
    parameter int N_LEDS   = 8,
    parameter int TICK_DIV = 3000000,
    parameter int DIV_W    = 22,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          mode,
    input  logic [N_LEDS-1:0]   pattern,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                load,
    output logic [N_LEDS-1:0]   leds,
    output logic                tick
);

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

    logic [1:0]          mode_r;
    logic [N_LEDS-1:0]   pat_r;
    logic [PWM_BITS-1:0] duty_r;
    logic                dir_r;
    logic                phase_r;

    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    div_next;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;

    logic [N_LEDS-1:0]   rotate_pat;
    logic [N_LEDS-1:0]   bounce_pat;
    logic                bounce_dir;
    logic                bounce_hold;
    logic [N_LEDS-1:0]   shown_pat;

    // Tick is registered so it is high in exactly the cycle where div_cnt
    // sits at its terminal value.
    always_comb begin
        div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || load) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_next;
            tick    <= (div_next == DIV_LAST);
        end
    end

    always_comb begin
        rotate_pat = {pat_r[N_LEDS-2:0], pat_r[N_LEDS-1]};
    end

    // A block touching both ends (or an empty pattern) has nowhere to go.
    always_comb begin
        bounce_pat  = pat_r;
        bounce_dir  = dir_r;
        bounce_hold = (pat_r == '0) || (pat_r[N_LEDS-1] && pat_r[0]);
        if (!bounce_hold) begin
            if (dir_r == DIR_LEFT && pat_r[N_LEDS-1]) begin
                bounce_dir = DIR_RIGHT;
                bounce_pat = pat_r >> 1;
            end else if (dir_r == DIR_RIGHT && pat_r[0]) begin
                bounce_dir = DIR_LEFT;
                bounce_pat = pat_r << 1;
            end else if (dir_r == DIR_LEFT) begin
                bounce_pat = pat_r << 1;
            end else begin
                bounce_pat = pat_r >> 1;
            end
        end
    end

    // Load wins over a coincident tick; that edge never steps the animation.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= MODE_STATIC;
            pat_r   <= '0;
            duty_r  <= DUTY_FULL;
            dir_r   <= DIR_LEFT;
            phase_r <= 1'b1;
        end else if (load) begin
            mode_r  <= mode;
            pat_r   <= pattern;
            duty_r  <= duty;
            dir_r   <= DIR_LEFT;
            phase_r <= 1'b1;
        end else if (tick) begin
            case (mode_r)
                MODE_BLINK: begin
                    phase_r <= ~phase_r;
                end
                MODE_ROTATE: begin
                    pat_r <= rotate_pat;
                end
                MODE_BOUNCE: begin
                    pat_r <= bounce_pat;
                    dir_r <= bounce_dir;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    always_comb begin
        pwm_on    = (duty_r == DUTY_FULL) || (pwm_cnt < duty_r);
        shown_pat = (mode_r == MODE_BLINK && !phase_r) ? '0 : pat_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= '0;
        end else begin
            leds <= shown_pat & {N_LEDS{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a cycle model predicts leds/tick,
// a monitor compares every cycle, and directed checks pin the key sequences.
module tb_led_pattern_gen;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] pattern;
    logic [1:0] duty;
    logic       load;
    logic [7:0] leds;
    logic       tick;

    led_pattern_gen #(
        .N_LEDS   (8),
        .TICK_DIV (TD),
        .DIV_W    (3),
        .PWM_BITS (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .pattern (pattern),
        .duty    (duty),
        .load    (load),
        .leds    (leds),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];

    int m_mode, m_pat, m_duty, m_right, m_phase, m_cnt, m_pwm, m_tick, m_leds;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: what the outputs must be right after the coming clock edge.
    task automatic model_edge();
        int nl;
        if (rst) begin
            m_mode = 0; m_pat = 0; m_duty = 3; m_right = 0; m_phase = 1;
            m_cnt = 0; m_pwm = 0; m_tick = 0; m_leds = 0;
        end else begin
            nl = (m_mode == 1 && m_phase == 0) ? 0 : m_pat;
            if (!(m_duty == 3 || m_pwm < m_duty)) nl = 0;
            m_leds = nl;
            m_pwm = (m_pwm + 1) % 4;
            if (load) begin
                m_mode = int'(mode); m_pat = int'(pattern); m_duty = int'(duty);
                m_right = 0; m_phase = 1; m_cnt = 0; m_tick = 0;
            end else begin
                if (m_tick == 1) begin
                    case (m_mode)
                        1: m_phase = 1 - m_phase;
                        2: m_pat = ((m_pat << 1) | (m_pat >> 7)) & 255;
                        3: begin
                            if (m_pat == 0 || (m_pat & 'h81) == 'h81) begin
                            end else if (m_right == 0 && (m_pat & 'h80) != 0) begin
                                m_right = 1; m_pat = m_pat >> 1;
                            end else if (m_right == 1 && (m_pat & 1) != 0) begin
                                m_right = 0; m_pat = (m_pat << 1) & 255;
                            end else if (m_right == 0) begin
                                m_pat = (m_pat << 1) & 255;
                            end else begin
                                m_pat = m_pat >> 1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                m_cnt = (m_cnt + 1) % TD;
                m_tick = (m_cnt == TD - 1) ? 1 : 0;
            end
        end
        exp_q.push_back(9'(m_leds * 2 + m_tick));
    endtask

    task automatic cycle();
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_tick();
        int k = 0;
        while (tick !== 1'b1 && k < 12) begin
            cycle();
            k++;
        end
        if (k >= 12) chk("tick_timeout", 0, 1);
    endtask

    task automatic step_check(input string name, input logic [7:0] exp);
        wait_tick();
        cycle();
        cycle();
        chk(name, leds, exp);
    endtask

    task automatic load_cfg(input logic [1:0] m, input logic [7:0] p, input logic [1:0] d);
        mode = m; pattern = p; duty = d; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
    endtask

    initial begin : monitor
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("scoreboard {leds,tick}", {leds, tick}, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [7:0] rot_exp [8];
        logic [7:0] bnc_exp [15];
        int n;
        rot_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        bnc_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

        rst = 1'b1; load = 1'b0; mode = 2'd0; pattern = 8'h00; duty = 2'd0;
        repeat (3) cycle();
        rst = 1'b0;
        chk("reset_leds", leds, 0);
        chk("reset_tick", tick, 0);

        load_cfg(2'd0, 8'hA5, 2'd3);
        chk("static_load", leds, 8'hA5);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (tick === 1'b1) n++;
            cycle();
        end
        chk("static_tick_count", n, 3);
        chk("static_hold", leds, 8'hA5);

        load_cfg(2'd2, 8'h81, 2'd3);
        for (int i = 0; i < 8; i++) step_check($sformatf("rotate_step%0d", i), rot_exp[i]);

        load_cfg(2'd3, 8'h01, 2'd3);
        for (int i = 0; i < 15; i++) step_check($sformatf("bounce_step%0d", i), bnc_exp[i]);
        load_cfg(2'd3, 8'h81, 2'd3);
        for (int i = 0; i < 5; i++) step_check("bounce_hold81", 8'h81);
        load_cfg(2'd3, 8'h00, 2'd3);
        for (int i = 0; i < 5; i++) step_check("bounce_hold00", 8'h00);

        load_cfg(2'd1, 8'hFF, 2'd3);
        chk("blink_start", leds, 8'hFF);
        step_check("blink_off1", 8'h00);
        step_check("blink_on", 8'hFF);
        step_check("blink_off2", 8'h00);
        wait_tick();
        mode = 2'd1; pattern = 8'hFF; load = 1'b1;
        cycle();
        load = 1'b0;
        n = 1;
        while (tick !== 1'b1 && n < 12) begin
            cycle();
            n++;
        end
        chk("reload_tick_gap", n, 4);

        load_cfg(2'd2, 8'h01, 2'd3);
        wait_tick();
        mode = 2'd2; pattern = 8'h40; load = 1'b1;
        cycle();
        load = 1'b0;
        cycle();
        chk("load_on_tick_no_step", leds, 8'h40);

        for (int d = 0; d < 4; d++) begin
            load_cfg(2'd0, 8'hFF, 2'(d));
            cycle();
            n = 0;
            for (int i = 0; i < 8; i++) begin
                if (leds === 8'hFF) n++;
                cycle();
            end
            chk($sformatf("pwm_duty%0d", d), n, (d == 3) ? 8 : 2 * d);
        end

        load_cfg(2'd3, 8'h01, 2'd3);
        for (int i = 0; i < 8; i++) step_check($sformatf("pre_rst_bounce%0d", i), bnc_exp[i]);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrun_rst_leds", leds, 0);
        chk("midrun_rst_tick", tick, 0);
        load_cfg(2'd3, 8'h10, 2'd3);
        step_check("post_rst_bounce_left", 8'h20);

        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 59) == 0);
            load = ($urandom_range(0, 11) == 0);
            if (load) begin
                mode    = 2'($urandom_range(0, 3));
                pattern = 8'($urandom);
                duty    = ($urandom_range(0, 1) == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            end
            cycle();
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (4) cycle();

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
